// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder plus a carry flop, operands
// shifted LSB-first, ready/start request side and valid/ack result side.

module serial_add_bfa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  always_comb begin
    s_o = a_i ^ b_i ^ c_i;
    c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
  end

endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic               bfa_s;
  logic               bfa_c;
  logic               last_bit;
  logic [WIDTH-1:0]   res_shift;

  serial_add_bfa u_bfa (
    .a_i (sh_a_q[0]),
    .b_i (sh_b_q[0]),
    .c_i (carry_q),
    .s_o (bfa_s),
    .c_o (bfa_c)
  );

  assign last_bit = (count_q == CNT_W'(WIDTH - 1));

  // Sum bits enter at the MSB; a single-bit result has nothing to shift down.
  if (WIDTH == 1) begin : g_res_w1
    assign res_shift = bfa_s;
  end else begin : g_res_wn
    assign res_shift = {bfa_s, result_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      carry_q  <= 1'b0;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (out_ack)  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Counter holds on the MSB edge so it never wraps, even at WIDTH == 2**CNT_W.
  always_comb begin
    count_d  = count_q;
    carry_d  = carry_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_a_d   = a;
          sh_b_d   = b ^ {WIDTH{sub}};
          carry_d  = sub;
          count_d  = '0;
          result_d = '0;
        end
      end
      RUN: begin
        result_d = res_shift;
        sh_a_d   = sh_a_q >> 1;
        sh_b_d   = sh_b_q >> 1;
        carry_d  = bfa_c;
        if (last_bit) begin
          cout_d = bfa_c;
          ovf_d  = carry_q ^ bfa_c;
          zero_d = (res_shift == '0);
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    cout      = cout_q;
    ovf       = ovf_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.

module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn8, st8, sb8, rdy8, vld8, ack8, co8, ov8, z8;
  logic [7:0] a8, b8, res8;
  logic       rn1, st1, sb1, rdy1, vld1, ack1, co1, ov1, z1;
  logic       a1, b1, res1;

  serial_add_ctrl #(.WIDTH(8), .CNT_W(5)) u_dut8 (
    .clk(clk), .reset_n(rn8), .start(st8), .sub(sb8), .a(a8), .b(b8),
    .in_ready(rdy8), .out_valid(vld8), .out_ack(ack8),
    .result(res8), .cout(co8), .ovf(ov8), .zero(z8)
  );

  serial_add_ctrl #(.WIDTH(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .reset_n(rn1), .start(st1), .sub(sb1), .a(a1), .b(b1),
    .in_ready(rdy1), .out_valid(vld1), .out_ack(ack1),
    .result(res1), .cout(co1), .ovf(ov1), .zero(z1)
  );

  typedef struct packed {
    logic [7:0] res;
    logic       co;
    logic       ov;
    logic       z;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Signed overflow: operands of equal sign giving a result of the other sign.
  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [7:0] bb;
    logic [8:0] s;
    exp_t       e;
    bb    = sub ? ~b : b;
    s     = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
    e.res = s[7:0];
    e.co  = s[8];
    e.ov  = (a[7] == bb[7]) && (s[7] != a[7]);
    e.z   = (s[7:0] == 8'd0);
    return e;
  endfunction

  function automatic exp_t model1(input logic a, input logic b, input logic sub);
    logic       bb;
    logic [1:0] s;
    exp_t       e;
    bb    = b ^ sub;
    s     = {1'b0, a} + {1'b0, bb} + {1'b0, sub};
    e.res = {7'd0, s[0]};
    e.co  = s[1];
    e.ov  = (a == bb) && (s[0] != a);
    e.z   = ~s[0];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sub, input bit noise);
    int   lat;
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      if (rdy8) break;
      tick();
    end
    check("w8_ready", rdy8, 1);
    a8 = a; b8 = b; sb8 = sub; st8 = 1'b1;
    q8.push_back(model8(a, b, sub));
    tick();
    check("w8_accept", rdy8, 0);
    if (!noise) st8 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (noise) begin
        a8 = 8'($urandom); b8 = 8'($urandom); sb8 = 1'($urandom); st8 = 1'b1;
      end
      tick();
      if (vld8) begin
        lat = i;
        break;
      end
    end
    check("w8_latency", 32'(lat), 8);
    e = q8.pop_front();
    check("w8_result", res8, e.res);
    check("w8_cout", co8, e.co);
    check("w8_ovf", ov8, e.ov);
    check("w8_zero", z8, e.z);
    if (noise) begin
      for (int i = 0; i < 5; i++) begin
        a8 = 8'($urandom); b8 = 8'($urandom); st8 = 1'b1; ack8 = 1'b0;
        tick();
        check("w8_hold_valid", vld8, 1);
        check("w8_hold_result", res8, e.res);
      end
    end
    st8 = 1'b0; ack8 = 1'b1;
    tick();
    ack8 = 1'b0;
    check("w8_valid_drop", vld8, 0);
    check("w8_ready_after_ack", rdy8, 1);
    check("w8_result_kept", res8, e.res);
  endtask

  task automatic run1(input logic a, input logic b, input logic sub);
    int   lat;
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      if (rdy1) break;
      tick();
    end
    check("w1_ready", rdy1, 1);
    a1 = a; b1 = b; sb1 = sub; st1 = 1'b1;
    q1.push_back(model1(a, b, sub));
    tick();
    st1 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (vld1) begin
        lat = i;
        break;
      end
    end
    check("w1_latency", 32'(lat), 1);
    e = q1.pop_front();
    check("w1_result", res1, e.res[0]);
    check("w1_cout", co1, e.co);
    check("w1_ovf", ov1, e.ov);
    check("w1_zero", z1, e.z);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("w1_valid_drop", vld1, 0);
  endtask

  initial begin
    bit seen;
    rn8 = 1'b0; st8 = 1'b0; sb8 = 1'b0; a8 = 8'h00; b8 = 8'h00; ack8 = 1'b0;
    rn1 = 1'b0; st1 = 1'b0; sb1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  ack1 = 1'b0;
    tick();
    tick();
    rn8 = 1'b1; rn1 = 1'b1;
    check("rst_ready", rdy8, 1);
    check("rst_valid", vld8, 0);
    check("rst_result", res8, 0);
    check("rst_flags", {co8, ov8, z8}, 0);
    check("rst_w1", {rdy1, vld1, res1, co1, ov1, z1}, 6'b100000);

    run8(8'h0F, 8'h01, 1'b0, 1'b0);
    run8(8'h05, 8'h07, 1'b1, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 1'b0);
    run8(8'h3C, 8'h5A, 1'b1, 1'b1);
    run8(8'h80, 8'h01, 1'b1, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0);

    // Reset lands on the 4th RUN edge of this op; no result may follow.
    a8 = 8'h33; b8 = 8'h44; sb8 = 1'b0; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    repeat (3) tick();
    rn8 = 1'b0;
    tick();
    rn8 = 1'b1;
    check("midrun_rst_ready", rdy8, 1);
    check("midrun_rst_valid", vld8, 0);
    check("midrun_rst_result", res8, 0);
    check("midrun_rst_flags", {co8, ov8, z8}, 0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (vld8) seen = 1'b1;
    end
    check("midrun_no_valid", seen, 0);

    ack8 = 1'b1;
    tick();
    ack8 = 1'b0;
    check("stray_ack_ignored", {rdy8, vld8}, 2'b10);

    for (int i = 0; i < 600; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
    for (int i = 0; i < 400; i++)
      run1(1'($urandom), 1'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
